// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch PC sequencer with RUN/HOLD/FLUSH control and a
//               post-redirect bubble window. Optional macro
//               PC_SEQUENCER_REDIRECT_COUNT_EN adds a saturating redirect count.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int unsigned        WIDTH        = 32,
    parameter logic [WIDTH-1:0]   PC_RESET     = '0,
    parameter logic [WIDTH-1:0]   INCR         = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned        FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_pc_sel,
    input  logic [WIDTH-1:0] in_target,
    input  logic             in_stall,
    input  logic             in_imem_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic             out_fetch_valid,
    output logic             out_flush,
    output logic [1:0]       out_state
`ifdef PC_SEQUENCER_REDIRECT_COUNT_EN
    ,
    output logic [15:0]      out_redirect_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             flush_q, flush_d;
    logic             blocked;

    assign blocked = in_stall | ~in_imem_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        // A redirect outranks stall/ready in every state, including FLUSH.
        if (in_pc_sel) begin
            pc_d    = in_target;
            cnt_d   = FLUSH_LOAD;
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (blocked) state_d = ST_HOLD;
                    else         pc_d    = pc_q + INCR;
                end
                ST_HOLD: begin
                    if (!blocked) state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        fetch_valid_d = (state_d != ST_FLUSH);
        flush_d       = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= PC_RESET;
            cnt_q         <= 4'd0;
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
        end
    end

    assign out_pc          = pc_q;
    assign out_fetch_valid = fetch_valid_q;
    assign out_flush       = flush_q;
    assign out_state       = state_q;

`ifdef PC_SEQUENCER_REDIRECT_COUNT_EN
    logic [15:0] redir_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            redir_cnt_q <= 16'd0;
        else if (in_pc_sel && (redir_cnt_q != 16'hFFFF))
            redir_cnt_q <= redir_cnt_q + 16'd1;
    end

    assign out_redirect_count = redir_cnt_q;
`else
    // Redirect counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, PC and target width in bits.
REQ-002 Parameter PC_RESET, default 0, PC value loaded on reset.
REQ-003 Parameter INCR, default 1, sequential PC increment.
REQ-004 Parameter FLUSH_CYCLES, default 2, bubble cycles after a taken redirect; legal range 1-15.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-007 in_pc_sel  input  1  taken branch/jump decision; 1 = redirect to in_target this cycle.
REQ-008 in_target  input  WIDTH  branch/jump destination address.
REQ-009 in_stall  input  1  downstream pipeline stall request.
REQ-010 in_imem_ready  input  1  instruction memory accepts the fetch at out_pc this cycle.
REQ-011 out_pc  output  WIDTH  current fetch address.
REQ-012 out_fetch_valid  output  1  out_pc is a valid fetch request this cycle.
REQ-013 out_flush  output  1  kill younger in-flight instructions; high during every FLUSH cycle.
REQ-014 out_state  output  2  encoded FSM state, for debug: RUN=0, HOLD=1, FLUSH=2.

Function
REQ-015 The FSM SHALL have exactly three states, RUN, HOLD and FLUSH; codes 3 SHALL map to RUN on the next edge.
REQ-016 Decision priority each edge SHALL be rst > in_pc_sel > (in_stall or !in_imem_ready) > advance.
REQ-017 RUN: in_pc_sel=1 SHALL load out_pc<=in_target, load flush counter with FLUSH_CYCLES, and enter FLUSH.
REQ-018 RUN: in_pc_sel=0 with in_stall=1 or in_imem_ready=0 SHALL hold out_pc and enter HOLD.
REQ-019 RUN: in_pc_sel=0, in_stall=0, in_imem_ready=1 SHALL update out_pc<=out_pc+INCR and stay in RUN.
REQ-020 HOLD: out_pc SHALL hold; return to RUN on the first edge with in_stall=0 and in_imem_ready=1, without advancing out_pc on that edge.
REQ-021 HOLD: in_pc_sel=1 SHALL redirect exactly as in REQ-017.
REQ-022 FLUSH: out_pc SHALL hold; counter decrements each edge; on the edge where counter reaches 0 the FSM SHALL enter RUN.
REQ-023 FLUSH: in_pc_sel=1 SHALL load the new in_target and reload the counter to FLUSH_CYCLES (flush window restarts).
REQ-024 FLUSH: in_stall and in_imem_ready SHALL be ignored.
REQ-025 out_fetch_valid SHALL be 1 in RUN and HOLD, 0 in FLUSH; out_flush SHALL be 1 in FLUSH only.
REQ-026 All outputs SHALL be registered; redirect latency from in_pc_sel sampled high to new out_pc visible SHALL be 1 cycle.
REQ-027 Increment SHALL wrap modulo 2^WIDTH (all-ones + 1 = 0) with no error indication.
REQ-028 in_target SHALL be used unmodified; no alignment masking.

Reset
REQ-029 On rst=1 at a rising edge: out_pc<=PC_RESET, state<=RUN, flush counter<=0, out_fetch_valid<=1, out_flush<=0, regardless of in_pc_sel or current state, including mid-FLUSH.
REQ-030 Power-up initial values SHALL equal the reset values.

Configuration
REQ-031 Macro PC_SEQUENCER_REDIRECT_COUNT_EN, when defined, SHALL add output out_redirect_count (16 bits) counting edges on which a redirect was taken, saturating at 0xFFFF, cleared by rst.
REQ-032 With PC_SEQUENCER_REDIRECT_COUNT_EN undefined, the port and counter SHALL be absent and all other behaviour identical.

Verification
REQ-033 Reset then 4 cycles of in_stall=0, in_imem_ready=1 -> out_pc 0,1,2,3,4; out_fetch_valid=1 throughout.
REQ-034 At out_pc=5 pulse in_pc_sel=1 with in_target=0x40 -> next cycle out_pc=0x40, out_flush=1 for 2 cycles, out_fetch_valid=0 for 2 cycles, then out_pc 0x41 on the following advance.
REQ-035 In FLUSH cycle 1, second redirect to 0x80 -> out_pc=0x80, flush window restarts, total out_flush high 3 consecutive cycles.
REQ-036 in_stall=1 and in_pc_sel=1 in the same cycle with in_target=0x10 -> redirect wins: out_pc=0x10, state FLUSH.
REQ-037 Preload out_pc=0xFFFFFFFF via redirect, let flush expire, advance once -> out_pc=0x00000000.
REQ-038 Assert rst during FLUSH -> next cycle out_pc=PC_RESET, out_flush=0, out_state=RUN; with the macro defined, out_redirect_count=0.
